// File: rtl/mdu_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// == Module   : mdu_issue_ctrl_if                                           ==
// == Purpose  : Bundles the EXE-stage pipeline controls, the multiplier and  ==
// ==            divider handshakes, and the HILO write strobe of the MDU     ==
// ==            issue controller into one connection.                        ==
// == Modports : slave  - the issue controller (consumes EXE/divider status, ==
// ==                     drives launches, stall and finish)                  ==
// ==            master - the surrounding pipeline / datapath side            ==
// == Signals  : EXE_Flush, EXE_Wr, mdu_op_valid, mdu_op[3:0],               ==
// ==            div_divisor_zero, div_done              (master -> slave)    ==
// ==            mul_start, mul_signed, div_start, div_signed, div_abort,     ==
// ==            EXE_MULTDIVStall, EXE_Finish, EXE_MultiExtendOp[1:0],        ==
// ==            mdu_div_zero                            (slave -> master)    ==
// == Revision : 1.0  initial release                                        ==
// ============================================================================
interface mdu_issue_ctrl_if;
  logic       EXE_Flush;
  logic       EXE_Wr;
  logic       mdu_op_valid;
  logic [3:0] mdu_op;
  logic       div_divisor_zero;
  logic       div_done;
  logic       mul_start;
  logic       mul_signed;
  logic       div_start;
  logic       div_signed;
  logic       div_abort;
  logic       EXE_MULTDIVStall;
  logic       EXE_Finish;
  logic [1:0] EXE_MultiExtendOp;
  logic       mdu_div_zero;

  modport slave (
    input  EXE_Flush, EXE_Wr, mdu_op_valid, mdu_op, div_divisor_zero, div_done,
    output mul_start, mul_signed, div_start, div_signed, div_abort,
           EXE_MULTDIVStall, EXE_Finish, EXE_MultiExtendOp, mdu_div_zero
  );

  modport master (
    output EXE_Flush, EXE_Wr, mdu_op_valid, mdu_op, div_divisor_zero, div_done,
    input  mul_start, mul_signed, div_start, div_signed, div_abort,
           EXE_MULTDIVStall, EXE_Finish, EXE_MultiExtendOp, mdu_div_zero
  );
endinterface
`default_nettype wire

// File: rtl/mdu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// == Module   : mdu_issue_ctrl                                             ==
// == Purpose  : Sequencer for the EXE-stage multiply/divide resource.       ==
// ==            Decodes the MDU op class, issues it exactly once to a       ==
// ==            fixed-latency pipelined multiplier or a start/done divider, ==
// ==            stalls the pipeline while busy, then emits a one-cycle      ==
// ==            EXE_Finish with the HILO extend op. EXE_Flush aborts.       ==
// == Ports    : clk  - clock                                               ==
// ==            rst  - synchronous active-high reset                       ==
// ==            bus  - mdu_issue_ctrl_if.slave (EXE controls, multiplier/  ==
// ==                   divider handshakes, stall, finish, extend op)       ==
// == Params   : MUL_LAT - multiplier pipeline depth in cycles (>=1)        ==
// ==            CNT_W   - latency counter width, 2**CNT_W > MUL_LAT        ==
// == Macro    : MDU_DIVZERO_FAST_EN - divide-by-zero skips the divider and ==
// ==            finishes the cycle after issue with mdu_div_zero=1         ==
// == Revision : 1.0  initial release                                      ==
// ============================================================================
module mdu_issue_ctrl #(
  parameter int MUL_LAT = 2,
  parameter int CNT_W   = 3
) (
  input  logic             clk,
  input  logic             rst,
  mdu_issue_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MUL_WAIT = 3'd1,
    S_DIV_WAIT = 3'd2,
    S_DONE     = 3'd3,
    S_HOLD     = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] MUL_CNT_INIT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       ext_q, ext_d;
  logic             dz_q, dz_d;

  // Op decode
  logic       is_mul_w;
  logic       is_div_w;
  logic       op_signed_w;
  logic [1:0] op_ext_w;

  always_comb begin
    is_mul_w    = 1'b0;
    is_div_w    = 1'b0;
    op_signed_w = 1'b0;
    op_ext_w    = 2'b00;
    case (bus.mdu_op)
      4'd1: begin is_mul_w = 1'b1; op_signed_w = 1'b1; end                     // MULT
      4'd2: begin is_mul_w = 1'b1; end                                         // MULTU
      4'd3: begin is_div_w = 1'b1; op_signed_w = 1'b1; end                     // DIV
      4'd4: begin is_div_w = 1'b1; end                                         // DIVU
      4'd5: begin is_mul_w = 1'b1; op_signed_w = 1'b1; op_ext_w = 2'b01; end   // MADD
      4'd6: begin is_mul_w = 1'b1; op_ext_w = 2'b01; end                       // MADDU
      4'd7: begin is_mul_w = 1'b1; op_signed_w = 1'b1; op_ext_w = 2'b10; end   // MSUB
      4'd8: begin is_mul_w = 1'b1; op_ext_w = 2'b10; end                       // MSUBU
      default: ;                                                               // NONE / reserved
    endcase
  end

  // Divide-by-zero fast path: the result is architecturally undefined, so the
  // divider is never engaged and the op completes the cycle after issue.
  logic div_fast_w;
`ifdef MDU_DIVZERO_FAST_EN
  assign div_fast_w = is_div_w & bus.div_divisor_zero;
`else
  logic unused_divisor_zero;
  assign unused_divisor_zero = bus.div_divisor_zero;
  assign div_fast_w          = 1'b0;
`endif

  // Outputs are suppressed while rst is high (no Finish/abort on a reset
  // mid-op) and flush suppresses everything except the divider kill.
  logic go_w;
  logic issue_w;
  assign go_w    = ~rst & ~bus.EXE_Flush;
  // Issue only from IDLE: an op held in EXE (HOLD) is never re-launched.
  assign issue_w = go_w & (state_q == S_IDLE) & bus.mdu_op_valid & (is_mul_w | is_div_w);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ext_d   = ext_q;
    dz_d    = dz_q;
    case (state_q)
      S_IDLE: begin
        if (issue_w) begin
          ext_d = op_ext_w;
          dz_d  = div_fast_w;
          if (is_mul_w) begin
            cnt_d   = MUL_CNT_INIT;
            // A single-stage multiplier already has its result next cycle.
            state_d = (MUL_LAT == 1) ? S_DONE : S_MUL_WAIT;
          end else if (div_fast_w) begin
            state_d = S_DONE;
          end else begin
            state_d = S_DIV_WAIT;
          end
        end
      end
      S_MUL_WAIT: begin
        // The counter holds the remaining wait cycles including this one;
        // leaving on the last one lands DONE exactly MUL_LAT after issue.
        if (cnt_q <= CNT_ONE) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_DIV_WAIT: begin
        if (bus.div_done) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = bus.EXE_Wr ? S_IDLE : S_HOLD;
      end
      S_HOLD: begin
        if (bus.EXE_Wr) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Flush drops whatever is in flight, including a multiplier result.
    if (bus.EXE_Flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ext_q   <= 2'b00;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ext_q   <= ext_d;
      dz_q    <= dz_d;
    end
  end

  // Output decode
  logic finish_w;
  assign finish_w = go_w & (state_q == S_DONE);

  assign bus.mul_start         = issue_w & is_mul_w;
  assign bus.mul_signed        = issue_w & is_mul_w & op_signed_w;
  assign bus.div_start         = issue_w & is_div_w & ~div_fast_w;
  assign bus.div_signed        = issue_w & is_div_w & ~div_fast_w & op_signed_w;
  assign bus.div_abort         = ~rst & bus.EXE_Flush & (state_q == S_DIV_WAIT);
  assign bus.EXE_MULTDIVStall  = issue_w |
                                 (go_w & ((state_q == S_MUL_WAIT) | (state_q == S_DIV_WAIT)));
  assign bus.EXE_Finish        = finish_w;
  assign bus.EXE_MultiExtendOp = finish_w ? ext_q : 2'b00;
  assign bus.mdu_div_zero      = finish_w & dz_q;

endmodule
`default_nettype wire

// File: tb/tb_mdu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// == Module   : tb_mdu_issue_ctrl                                          ==
// == Purpose  : Directed self-checking bench for mdu_issue_ctrl with       ==
// ==            MUL_LAT=2. Each cycle the full output vector is compared   ==
// ==            against a hand-computed value.                             ==
// == Vector   : {mul_start, mul_signed, div_start, div_signed, div_abort,  ==
// ==             stall, finish, ext[1:0], div_zero}                        ==
// == Macro    : MDU_DIVZERO_FAST_EN selects the divide-by-zero expectations==
// == Revision : 1.0  initial release                                      ==
// ============================================================================
module tb_mdu_issue_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mdu_issue_ctrl_if mif();

  mdu_issue_ctrl #(
    .MUL_LAT (2),
    .CNT_W   (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (mif)
  );

  int n_vec = 0;
  int n_err = 0;

  localparam logic [9:0] MS  = 10'b10_0000_0000;
  localparam logic [9:0] MSG = 10'b01_0000_0000;
  localparam logic [9:0] DS  = 10'b00_1000_0000;
  localparam logic [9:0] DSG = 10'b00_0100_0000;
  localparam logic [9:0] AB  = 10'b00_0010_0000;
  localparam logic [9:0] ST  = 10'b00_0001_0000;
  localparam logic [9:0] FIN = 10'b00_0000_1000;
  localparam logic [9:0] X10 = 10'b00_0000_0100;
  localparam logic [9:0] X01 = 10'b00_0000_0010;
  localparam logic [9:0] DZ  = 10'b00_0000_0001;
  localparam logic [9:0] NO  = 10'b00_0000_0000;

  function automatic logic [9:0] obs_vec();
    return {mif.mul_start, mif.mul_signed, mif.div_start, mif.div_signed, mif.div_abort,
            mif.EXE_MULTDIVStall, mif.EXE_Finish, mif.EXE_MultiExtendOp, mif.mdu_div_zero};
  endfunction

  task automatic check_val(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (ms,msg,ds,dsg,abort,stall,fin,ext1,ext0,dz)",
               tag, obs, exp);
    end
  endtask

  task automatic drv(input logic fl, input logic wr, input logic v, input logic [3:0] op,
                     input logic dz, input logic dn);
    mif.EXE_Flush        = fl;
    mif.EXE_Wr           = wr;
    mif.mdu_op_valid     = v;
    mif.mdu_op           = op;
    mif.div_divisor_zero = dz;
    mif.div_done         = dn;
  endtask

  // Check the current cycle's outputs, then advance to just after the next edge.
  task automatic cyc(input string tag, input logic [9:0] exp);
    #1;
    check_val(tag, obs_vec(), exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset: outputs held at 0 even with a valid op presented.
    rst = 1'b1;
    drv(0, 0, 1, 4'd1, 0, 0);
    @(posedge clk);
    #1;
    cyc("reset_a", NO);
    cyc("reset_b", NO);
    rst = 1'b0;
    drv(0, 0, 0, 4'd0, 0, 0);
    cyc("idle_after_reset", NO);

    // MULT: start@0, stall@0-1, finish@2 ext 00, back to IDLE@3.
    drv(0, 0, 1, 4'd1, 0, 0); cyc("mult_issue", MS | MSG | ST);
    cyc("mult_wait", ST);
    drv(0, 1, 1, 4'd1, 0, 0); cyc("mult_finish", FIN);
    // MULTU right away proves IDLE; EXE_Wr high during the wait is ignored.
    drv(0, 1, 1, 4'd2, 0, 0); cyc("multu_issue", MS | ST);
    cyc("multu_wait_wr", ST);
    cyc("multu_finish", FIN);
    drv(0, 0, 0, 4'd0, 0, 0); cyc("multu_idle", NO);

    // DIVU with div_done at cycle 33: stall 0..33, finish@34.
    drv(0, 0, 1, 4'd4, 0, 0); cyc("divu_issue", DS | ST);
    for (int i = 1; i <= 33; i++) begin
      drv(0, 0, 1, 4'd4, 0, (i == 33));
      cyc($sformatf("divu_wait%0d", i), ST);
    end
    drv(0, 1, 1, 4'd4, 0, 0); cyc("divu_finish", FIN);
    drv(0, 0, 0, 4'd0, 0, 0); cyc("divu_idle", NO);

    // MSUB finishing while EXE_Wr=0: single finish ext 10, HOLD, no re-issue.
    drv(0, 0, 1, 4'd7, 0, 0); cyc("msub_issue", MS | MSG | ST);
    cyc("msub_wait", ST);
    cyc("msub_finish", FIN | X10);
    for (int i = 0; i < 3; i++) begin
      drv(0, 0, 1, 4'd7, 0, (i == 1));
      cyc($sformatf("msub_hold%0d", i), NO);
    end
    drv(0, 1, 1, 4'd7, 0, 0); cyc("msub_hold_release", NO);
    drv(0, 0, 0, 4'd0, 0, 0); cyc("msub_idle", NO);

    // MADDU: unsigned multiply, ext 01.
    drv(0, 1, 1, 4'd6, 0, 0); cyc("maddu_issue", MS | ST);
    cyc("maddu_wait", ST);
    cyc("maddu_finish", FIN | X01);
    drv(0, 0, 0, 4'd0, 0, 0); cyc("maddu_idle", NO);

    // DIV flushed at cycle 5: abort only, then a stray div_done is ignored.
    drv(0, 0, 1, 4'd3, 0, 0); cyc("div_issue", DS | DSG | ST);
    for (int i = 1; i <= 4; i++) cyc($sformatf("div_wait%0d", i), ST);
    drv(1, 0, 1, 4'd3, 0, 0); cyc("div_flush", AB);
    drv(0, 0, 0, 4'd0, 0, 1); cyc("div_late_done", NO);
    drv(0, 0, 0, 4'd0, 0, 0); cyc("div_after_flush", NO);

    // Flush in the issue cycle suppresses the start.
    drv(1, 0, 1, 4'd1, 0, 0); cyc("flush_issue", NO);
    drv(0, 0, 0, 4'd0, 0, 0); cyc("flush_issue_idle", NO);

    // Flush while a multiply is in flight drops the result.
    drv(0, 0, 1, 4'd5, 0, 0); cyc("madd_issue", MS | MSG | ST);
    drv(1, 0, 1, 4'd5, 0, 0); cyc("madd_flush", NO);
    drv(0, 0, 0, 4'd0, 0, 0); cyc("madd_no_finish", NO);

    // DIV with a zero divisor.
`ifdef MDU_DIVZERO_FAST_EN
    drv(0, 0, 1, 4'd3, 1, 0); cyc("divz_issue", ST);
    drv(0, 1, 1, 4'd3, 1, 0); cyc("divz_finish", FIN | DZ);
    drv(0, 0, 0, 4'd0, 0, 0); cyc("divz_idle", NO);
`else
    drv(0, 0, 1, 4'd3, 1, 0); cyc("divz_issue", DS | DSG | ST);
    cyc("divz_wait1", ST);
    drv(0, 0, 1, 4'd3, 1, 1); cyc("divz_done", ST);
    drv(0, 1, 1, 4'd3, 1, 0); cyc("divz_finish", FIN);
    drv(0, 0, 0, 4'd0, 0, 0); cyc("divz_idle", NO);
`endif

    // Reset mid-operation, then a reserved op code.
    drv(0, 0, 1, 4'd1, 0, 0); cyc("rstmid_issue", MS | MSG | ST);
    rst = 1'b1;                 cyc("rstmid_reset", NO);
    rst = 1'b0;
    drv(0, 0, 1, 4'd12, 0, 0);  cyc("op12_none", NO);
    drv(0, 0, 1, 4'd1, 0, 0);   cyc("rstmid_reissue", MS | MSG | ST);
    cyc("rstmid_wait", ST);
    drv(0, 1, 1, 4'd1, 0, 0);   cyc("rstmid_finish", FIN);
    drv(0, 0, 0, 4'd0, 0, 0);   cyc("final_idle", NO);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
